// File: rtl/insn_mem_defs.sv
// ============================================================================
// Module : insn_mem_defs (package)
// Brief  : Shared encodings and constants for the instruction-memory port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package insn_mem_defs;

    localparam int MEM_AW_DEF = 8;
    localparam int INSN_BYTES = 4;
    localparam int CNT_W      = $clog2(INSN_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module : rr_arbiter2
// Brief  : Two-requester round-robin grant with a registered last-grant pointer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 #(
    parameter bit RESET_LAST = 1'b1     // index treated as last granted out of reset
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last;

    // On contention the requester that did not win last time is served.
    always_comb begin
        gnt[0] = en & req[0] & (~req[1] | last);
        gnt[1] = en & req[1] & (~req[0] | ~last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= RESET_LAST;
        end else if (gnt[1]) begin
            last <= 1'b1;
        end else if (gnt[0]) begin
            last <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/insn_mem_arbiter.sv
// ============================================================================
// Module : insn_mem_arbiter
// Brief  : Shares a byte-wide synchronous-read memory between 4-byte fetch and byte loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module insn_mem_arbiter
    import insn_mem_defs::*;
#(
    parameter int MEM_AW = MEM_AW_DEF,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [31:0]       fetch_insn,
    output logic              fetch_fault,
    input  logic              load_req,
    input  logic [MEM_AW-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              load_ack,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int LO_W = 8 * (INSN_BYTES - 1);

    state_t            state;
    logic [MEM_AW-1:0] base;
    logic [CNT_W-1:0]  cnt;
    logic              fault_q;
    logic [LO_W-1:0]   lo_bytes;
    logic              arb_en;
    logic [1:0]        gnt;

    // Gating with rst_n keeps the combinational handshakes quiet during reset.
    assign arb_en = rst_n & (state == IDLE);

    rr_arbiter2 #(
        .RESET_LAST (1'b1)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   ({fetch_req, load_req}),
        .gnt   (gnt)
    );

    always_comb begin
        load_ack    = gnt[0];
        fetch_ready = gnt[1];
        mem_we      = gnt[0];
        mem_wdata   = gnt[0] ? load_data : 8'h00;
        mem_addr    = '0;
        if (gnt[0]) begin
            mem_addr = load_addr;
        end else if (gnt[1]) begin
            mem_addr = fetch_addr[MEM_AW-1:0];
        end else if (state == RD) begin
            mem_addr = base + MEM_AW'(cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base        <= '0;
            cnt         <= '0;
            fault_q     <= 1'b0;
            lo_bytes    <= '0;
            fetch_valid <= 1'b0;
            fetch_insn  <= 32'h0;
            fetch_fault <= 1'b0;
        end else begin
            fetch_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_ready) begin
                        base    <= fetch_addr[MEM_AW-1:0];
                        fault_q <= |fetch_addr[ADDR_W-1:MEM_AW];
                        cnt     <= CNT_W'(1);
                        state   <= RD;
                    end
                end
                RD: begin
                    // Bytes shift in from the top so byte 0 ends up lowest.
                    lo_bytes <= {mem_rdata, lo_bytes[LO_W-1:8]};
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(INSN_BYTES - 1)) begin
                        state <= CAP;
                    end
                end
                CAP: begin
                    fetch_valid <= 1'b1;
                    fetch_insn  <= {mem_rdata, lo_bytes};
                    fetch_fault <= fault_q;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_insn_mem_arbiter.sv
// ============================================================================
// Module : tb_insn_mem_arbiter
// Brief  : Directed self-checking bench with a fetch-result scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_insn_mem_arbiter;

    localparam int MEM_AW = 8;
    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [31:0]       fetch_insn;
    logic              fetch_fault;
    logic              load_req;
    logic [MEM_AW-1:0] load_addr;
    logic [7:0]        load_data;
    logic              load_ack;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    typedef struct {
        logic [31:0] insn;
        logic        fault;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [7:0]  mem   [256];

    insn_mem_arbiter #(
        .MEM_AW (MEM_AW),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_insn  (fetch_insn),
        .fetch_fault (fetch_fault),
        .load_req    (load_req),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ack    (load_ack),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory with one-cycle synchronous read.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && fetch_valid === 1'b1) begin
            chk("valid_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("fetch_insn", fetch_insn, mon_e.insn);
                chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, mon_e.fault});
                chk("fetch_latency", cyc, mon_e.cyc);
            end
        end
    end

    task automatic load_byte(input logic [7:0] a, input logic [7:0] d, output int ack_cyc);
        load_req  = 1'b1;
        load_addr = a;
        load_data = d;
        ack_cyc   = -1;
        for (int i = 0; i < 20 && ack_cyc < 0; i++) begin
            @(negedge clk);
            if (load_ack) ack_cyc = cyc;
            @(posedge clk);
            #1;
        end
        load_req = 1'b0;
        if (ack_cyc < 0) chk("load_timeout", 32'd0, 32'd1);
    endtask

    task automatic fetch(input logic [63:0] a, input logic [31:0] exp_insn,
                         input logic exp_fault, output int acc_cyc);
        exp_t e;
        fetch_req  = 1'b1;
        fetch_addr = a;
        acc_cyc    = -1;
        for (int i = 0; i < 20 && acc_cyc < 0; i++) begin
            @(negedge clk);
            if (fetch_ready) begin
                acc_cyc = cyc;
                e.insn  = exp_insn;
                e.fault = exp_fault;
                e.cyc   = cyc + 5;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        fetch_req = 1'b0;
        if (acc_cyc < 0) chk("fetch_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int c0, c1, t0;
        int ack_c[4];
        logic [7:0] la[4];
        logic [7:0] ld[4];

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
        load_req = 1'b0; load_addr = '0; load_data = '0;
        repeat (2) @(posedge clk);
        #1;
        load_req = 1'b1; fetch_req = 1'b1;
        #1;
        chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_fetch_insn", fetch_insn, 32'd0);
        chk("rst_fetch_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        chk("rst_load_ack", {31'd0, load_ack}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        load_req = 1'b0; fetch_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Preload and basic fetch.
        load_byte(8'h00, 8'h13, c0);
        load_byte(8'h01, 8'h05, c0);
        load_byte(8'h02, 8'h10, c0);
        load_byte(8'h03, 8'h00, c0);
        t0 = cyc;
        fetch(64'h0, 32'h00100513, 1'b0, c0);
        chk("fetch_ready_cycle0", c0, t0);
        wait_drain();

        // Back-to-back loader writes.
        la = '{8'h10, 8'h11, 8'h12, 8'h13};
        ld = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 4; i++) load_byte(la[i], ld[i], ack_c[i]);
        for (int i = 1; i < 4; i++) chk("load_b2b", ack_c[i], ack_c[0] + i);
        fetch(64'h10, 32'hDDCCBBAA, 1'b0, c0);
        wait_drain();

        // Wraparound, out-of-range, and fetch accepted in the valid cycle.
        load_byte(8'hFF, 8'h11, c0);
        load_byte(8'h00, 8'h22, c0);
        load_byte(8'h01, 8'h33, c0);
        load_byte(8'h02, 8'h44, c0);
        load_byte(8'h20, 8'h01, c0);
        load_byte(8'h21, 8'h02, c0);
        load_byte(8'h22, 8'h03, c0);
        load_byte(8'h23, 8'h04, c0);
        fetch(64'hFF, 32'h44332211, 1'b0, c0);
        fetch(64'h100, 32'h00443322, 1'b1, c1);
        chk("refetch_in_valid_cycle", c1, c0 + 5);
        wait_drain();

        // Both requests held continuously after reset: L, F, busy x4, repeat.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load_req = 1'b1; load_addr = 8'h80; load_data = 8'h5A;
        fetch_req = 1'b1; fetch_addr = 64'h20;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("rr_load_ack", {31'd0, load_ack}, ((k % 6) == 0) ? 32'd1 : 32'd0);
            chk("rr_fetch_ready", {31'd0, fetch_ready}, ((k % 6) == 1) ? 32'd1 : 32'd0);
            if (fetch_ready) sb.push_back('{32'h04030201, 1'b0, cyc + 5});
            @(posedge clk);
            #1;
        end
        load_req = 1'b0; fetch_req = 1'b0;
        wait_drain();

        // Reset in cycle 2 of a fetch.
        fetch_req = 1'b1; fetch_addr = 64'h10;
        c0 = -1;
        for (int i = 0; i < 20 && c0 < 0; i++) begin
            @(negedge clk);
            if (fetch_ready) c0 = cyc;
            @(posedge clk);
            #1;
        end
        if (c0 < 0) chk("abort_fetch_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0; load_req = 1'b1;
        #1;
        chk("abort_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        chk("abort_fetch_insn", fetch_insn, 32'd0);
        chk("abort_fetch_fault", {31'd0, fetch_fault}, 32'd0);
        chk("abort_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        chk("abort_load_ack", {31'd0, load_ack}, 32'd0);
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("abort_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        load_req = 1'b0; fetch_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        fetch(64'h0, 32'h00443322, 1'b0, c0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
